// File: rtl/power_aes_pkg.sv
// Shared definitions for the AES power-analysis stimulus block: FSM state
// encoding, LFSR tap masks per supported width and the default LFSR seed.
package power_aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Tap masks hold bit (tap-1) set for each tap position.
  localparam logic [63:0] TAPS_32      = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS_64      = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'hACE1_ACE1_ACE1_ACE1;

  function automatic logic [63:0] lfsr_taps(input int w);
    return (w == 64) ? TAPS_64 : TAPS_32;
  endfunction

  function automatic logic lfsr_fb(input logic [63:0] s, input int w);
    return ^(s & lfsr_taps(w));
  endfunction

endpackage

// File: rtl/power_lfsr.sv
// Fibonacci LFSR, shift-left with feedback into bit 0; taps chosen by width.
module power_lfsr
  import power_aes_pkg::*;
#(
  parameter int           W    = 32,
  parameter logic [W-1:0] SEED = DEFAULT_SEED[W-1:0]
) (
  input  logic         ICE_CLK,
  input  logic         resetn,
  input  logic         shift_en,
  output logic [W-1:0] q
);

  logic fb;

  assign fb = lfsr_fb(64'(q), W);

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) begin
      q <= SEED;
    end else if (shift_en) begin
      q <= {q[W-2:0], fb};
    end
  end

endmodule

// File: rtl/power_aes_stim.sv
// Slot-timed AES launch, scope trigger and ciphertext digest for power capture.
// Optional fixed-vs-random (TVLA) plaintext selection under POWER_AES_TVLA_EN.
module power_aes_stim
  import power_aes_pkg::*;
#(
  parameter int             PERIOD    = 256,
  parameter int             START_CYC = 240,
  parameter int             LFSR_W    = 32,
  parameter logic [63:0]    SEED      = DEFAULT_SEED,
  parameter logic [127:0]   FIXED_PT  = 128'h0
) (
  input  logic         ICE_CLK,
  input  logic         resetn,
  input  logic         enable_i,
  input  logic         aes_busy_i,
  input  logic [127:0] aes_data_i,
  output logic         aes_start_o,
  output logic [127:0] aes_data_o,
  output logic         trigger_o,
  output logic         class_o,
  output logic [2:0]   digest_o,
  output logic [15:0]  enc_cnt_o,
  output logic         err_o
);

  if (PERIOD < 32 || PERIOD > 65535) begin : g_bad_period
    $error("PERIOD must lie in 32..65535");
  end
  if (START_CYC >= PERIOD - 2) begin : g_bad_start
    $error("START_CYC must be below PERIOD-2");
  end
  if (LFSR_W != 32 && LFSR_W != 64) begin : g_bad_width
    $error("LFSR_W must be 32 or 64");
  end
  if (SEED[LFSR_W-1:0] == '0) begin : g_bad_seed
    $error("SEED must be nonzero in its low LFSR_W bits");
  end
  if (^FIXED_PT === 1'bx) begin : g_bad_fixed
    $error("FIXED_PT must not contain unknown bits");
  end

  localparam logic [15:0] LAST_CYC   = 16'(PERIOD - 1);
  localparam logic [15:0] LAUNCH_CYC = 16'(START_CYC);

  state_t              state, state_nxt;
  logic [15:0]         cnt;
  logic                last, start, complete, timeout, skip, shift_en;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [127:0]        rand_pt;

  assign last     = (cnt == LAST_CYC);
  assign shift_en = enable_i && last && (state != IDLE);
  assign rand_pt  = {(128 / LFSR_W){lfsr_q}};

  power_lfsr #(
    .W    (LFSR_W),
    .SEED (SEED[LFSR_W-1:0])
  ) u_lfsr (
    .ICE_CLK  (ICE_CLK),
    .resetn   (resetn),
    .shift_en (shift_en),
    .q        (lfsr_q)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    skip      = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (!enable_i) begin
          state_nxt = IDLE;
        end else if (cnt == LAUNCH_CYC) begin
          if (!aes_busy_i) begin
            start     = 1'b1;
            state_nxt = RUN;
          end else begin
            skip = 1'b1;
          end
        end
      end
      RUN: begin
        // Completion beats timeout; with enable low the counter is frozen
        // and the encryption is simply allowed to finish.
        if (!aes_busy_i) begin
          complete  = 1'b1;
          state_nxt = !enable_i ? IDLE : (last ? WAIT : DONE);
        end else if (enable_i && last) begin
          timeout   = 1'b1;
          state_nxt = WAIT;
        end
      end
      DONE: begin
        if (!enable_i)  state_nxt = IDLE;
        else if (last)  state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign aes_start_o = start;
  assign trigger_o   = start || (state == RUN && aes_busy_i && !timeout);

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      err_o     <= 1'b0;
      digest_o  <= '0;
      enc_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        cnt <= '0;
      end else if (enable_i) begin
        cnt <= last ? '0 : cnt + 16'd1;
      end
      if (skip || timeout) err_o <= 1'b1;
      if (complete) begin
        digest_o  <= {^aes_data_i, &aes_data_i, |aes_data_i};
        enc_cnt_o <= enc_cnt_o + 16'd1;
      end
    end
  end

`ifdef POWER_AES_TVLA_EN
  logic cls;

  // The class for the coming slot is the bit the LFSR is about to shift in.
  always_ff @(posedge ICE_CLK) begin
    if (!resetn) begin
      cls <= 1'b0;
    end else if (shift_en) begin
      cls <= lfsr_fb(64'(lfsr_q), LFSR_W);
    end
  end

  assign class_o    = cls;
  assign aes_data_o = cls ? FIXED_PT : rand_pt;
`else
  assign class_o    = 1'b0;
  assign aes_data_o = rand_pt;
`endif

endmodule

// File: tb/tb_power_aes_stim.sv
// Self-checking bench for power_aes_stim with a behavioural AES busy model
// and a slot-level reference model of launches, LFSR plaintext and digests.
module tb_power_aes_stim;

  localparam logic [127:0] FIXED  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [31:0]  SEED32 = 32'hACE1_ACE1;
`ifdef POWER_AES_TVLA_EN
  localparam bit TVLA = 1'b1;
`else
  localparam bit TVLA = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic         busy   = 1'b0;
  logic [127:0] ct     = '0;
  logic         aes_start_o, trigger_o, class_o, err_o;
  logic [127:0] aes_data_o;
  logic [2:0]   digest_o;
  logic [15:0]  enc_cnt_o;

  int checks = 0;
  int errors = 0;

  logic rstn_nxt = 1'b0;
  logic en_nxt   = 1'b0;
  bit   force_busy = 1'b0;
  bit   hang = 1'b0;
  bit   running = 1'b0;
  bit   prev_start = 1'b0;
  int   busy_len = 4;
  int   busy_left = 0;
  int   cyc = 0;

  power_aes_stim #(
    .PERIOD    (256),
    .START_CYC (240),
    .LFSR_W    (32),
    .SEED      (64'hACE1_ACE1_ACE1_ACE1),
    .FIXED_PT  (FIXED)
  ) dut (
    .ICE_CLK     (clk),
    .resetn      (resetn),
    .enable_i    (enable),
    .aes_busy_i  (busy),
    .aes_data_i  (ct),
    .aes_start_o (aes_start_o),
    .aes_data_o  (aes_data_o),
    .trigger_o   (trigger_o),
    .class_o     (class_o),
    .digest_o    (digest_o),
    .enc_cnt_o   (enc_cnt_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [127:0] plaintext(input logic [31:0] s, input bit cls);
    return (TVLA && cls) ? FIXED : {s, s, s, s};
  endfunction

  function automatic logic [2:0] digest(input logic [127:0] d);
    return {^d, &d, |d};
  endfunction

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    resetn = rstn_nxt;
    enable = en_nxt;
    if (!resetn) begin
      running   = 1'b0;
      busy_left = 0;
    end else if (prev_start) begin
      running   = 1'b1;
      busy_left = busy_len;
      ct        = {$urandom, $urandom, $urandom, $urandom};
    end
    busy = force_busy || (busy_left > 0) || (running && hang);
    if (busy_left > 0) busy_left--;
    @(negedge clk);
    prev_start = aes_start_o;
    cyc++;
  endtask

  task automatic do_reset();
    en_nxt = 1'b0; rstn_nxt = 1'b0; force_busy = 1'b0; hang = 1'b0; busy_len = 4;
    repeat (3) tick();
    rstn_nxt = 1'b1;
    tick();
  endtask

  task automatic start_run();
    en_nxt = 1'b1;
    tick();
    cyc = 0;
  endtask

  task automatic test_reset();
    int n_act;
    do_reset();
    checks++; if (aes_start_o !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b expected 0", aes_start_o); end
    checks++; if (trigger_o !== 1'b0) begin errors++; $display("FAIL rst_trigger: got %0b expected 0", trigger_o); end
    checks++; if (class_o !== 1'b0) begin errors++; $display("FAIL rst_class: got %0b expected 0", class_o); end
    checks++; if (digest_o !== 3'd0) begin errors++; $display("FAIL rst_digest: got %0h expected 0", digest_o); end
    checks++; if (enc_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_enc_cnt: got %0d expected 0", enc_cnt_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b expected 0", err_o); end
    checks++; if (aes_data_o !== plaintext(SEED32, 1'b0)) begin errors++; $display("FAIL rst_data: got %0h expected %0h", aes_data_o, plaintext(SEED32, 1'b0)); end
    n_act = 0;
    repeat (300) begin
      if (aes_start_o || trigger_o) n_act++;
      tick();
    end
    checks++; if (n_act != 0) begin errors++; $display("FAIL disabled_quiet: got %0d active cycles expected 0", n_act); end
  endtask

  task automatic test_random_slots();
    logic [31:0] lf;
    bit cls;
    int len, n_start, n_trig, start_at, bad_pt;
    do_reset();
    start_run();
    lf = SEED32; cls = 1'b0;
    for (int s = 0; s < 6; s++) begin
      len = (s == 0) ? 12 : (s == 5) ? 14 : int'($urandom_range(0, 14));
      busy_len = len;
      n_start = 0; n_trig = 0; start_at = -1; bad_pt = 0;
      for (int c = 0; c < 256; c++) begin
        if (aes_start_o) begin n_start++; start_at = cyc; end
        if (trigger_o) n_trig++;
        if (aes_data_o !== plaintext(lf, cls) || class_o !== cls) bad_pt++;
        tick();
      end
      checks++; if (n_start != 1) begin errors++; $display("FAIL slot%0d_launches: got %0d expected 1", s, n_start); end
      checks++; if (start_at != s * 256 + 240) begin errors++; $display("FAIL slot%0d_launch_cycle: got %0d expected %0d", s, start_at, s * 256 + 240); end
      checks++; if (n_trig != len + 1) begin errors++; $display("FAIL slot%0d_trigger_len: got %0d expected %0d", s, n_trig, len + 1); end
      checks++; if (bad_pt != 0) begin errors++; $display("FAIL slot%0d_plaintext: got %0d bad cycles expected 0", s, bad_pt); end
      checks++; if (enc_cnt_o !== 16'(s + 1)) begin errors++; $display("FAIL slot%0d_enc_cnt: got %0d expected %0d", s, enc_cnt_o, s + 1); end
      checks++; if (digest_o !== digest(ct)) begin errors++; $display("FAIL slot%0d_digest: got %0h expected %0h", s, digest_o, digest(ct)); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL slot%0d_err: got %0b expected 0", s, err_o); end
      lf  = lfsr_step(lf);
      cls = TVLA ? lf[0] : 1'b0;
      checks++; if (aes_data_o !== plaintext(lf, cls)) begin errors++; $display("FAIL slot%0d_next_pt: got %0h expected %0h", s, aes_data_o, plaintext(lf, cls)); end
    end
  endtask

  task automatic test_skip();
    int n_start, start_at;
    do_reset();
    start_run();
    busy_len = 5;
    n_start = 0;
    for (int c = 0; c < 256; c++) begin
      if (c == 230) force_busy = 1'b1;
      if (c == 245) force_busy = 1'b0;
      if (aes_start_o) n_start++;
      tick();
    end
    checks++; if (n_start != 0) begin errors++; $display("FAIL skip_launches: got %0d expected 0", n_start); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL skip_err: got %0b expected 1", err_o); end
    checks++; if (enc_cnt_o !== 16'd0) begin errors++; $display("FAIL skip_enc_cnt: got %0d expected 0", enc_cnt_o); end
    start_at = -1;
    for (int c = 0; c < 256; c++) begin
      if (aes_start_o) start_at = cyc;
      tick();
    end
    checks++; if (start_at != 496) begin errors++; $display("FAIL skip_recover_launch: got %0d expected 496", start_at); end
    checks++; if (enc_cnt_o !== 16'd1) begin errors++; $display("FAIL skip_recover_cnt: got %0d expected 1", enc_cnt_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL skip_err_sticky: got %0b expected 1", err_o); end
  endtask

  task automatic test_timeout();
    int start_at, n_trig;
    do_reset();
    start_run();
    busy_len = 0;
    hang = 1'b1;
    for (int c = 0; c < 256; c++) begin
      if (c == 254) begin
        checks++; if (trigger_o !== 1'b1) begin errors++; $display("FAIL tmo_trigger_254: got %0b expected 1", trigger_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_err_254: got %0b expected 0", err_o); end
      end
      tick();
    end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0b expected 1", err_o); end
    checks++; if (trigger_o !== 1'b0) begin errors++; $display("FAIL tmo_trigger_256: got %0b expected 0", trigger_o); end
    checks++; if (enc_cnt_o !== 16'd0) begin errors++; $display("FAIL tmo_enc_cnt: got %0d expected 0", enc_cnt_o); end
    checks++; if (digest_o !== 3'd0) begin errors++; $display("FAIL tmo_digest: got %0h expected 0", digest_o); end
    hang = 1'b0; running = 1'b0; busy_len = 3;
    start_at = -1; n_trig = 0;
    for (int c = 0; c < 256; c++) begin
      if (aes_start_o) start_at = cyc;
      if (trigger_o) n_trig++;
      tick();
    end
    checks++; if (start_at != 496) begin errors++; $display("FAIL tmo_relaunch: got %0d expected 496", start_at); end
    checks++; if (n_trig != 4) begin errors++; $display("FAIL tmo_relaunch_trig: got %0d expected 4", n_trig); end
    checks++; if (enc_cnt_o !== 16'd1) begin errors++; $display("FAIL tmo_relaunch_cnt: got %0d expected 1", enc_cnt_o); end
  endtask

  task automatic test_enable_fall();
    int n_act, start_at;
    do_reset();
    start_run();
    busy_len = 10;
    for (int c = 0; c < 244; c++) tick();
    en_nxt = 1'b0;
    repeat (4) tick();
    checks++; if (trigger_o !== 1'b1) begin errors++; $display("FAIL enfall_trigger_held: got %0b expected 1", trigger_o); end
    repeat (3) tick();
    checks++; if (trigger_o !== 1'b0) begin errors++; $display("FAIL enfall_trigger_drop: got %0b expected 0", trigger_o); end
    tick();
    checks++; if (enc_cnt_o !== 16'd1) begin errors++; $display("FAIL enfall_enc_cnt: got %0d expected 1", enc_cnt_o); end
    checks++; if (digest_o !== digest(ct)) begin errors++; $display("FAIL enfall_digest: got %0h expected %0h", digest_o, digest(ct)); end
    n_act = 0;
    repeat (40) begin
      if (aes_start_o || trigger_o) n_act++;
      tick();
    end
    checks++; if (n_act != 0) begin errors++; $display("FAIL enfall_idle_quiet: got %0d expected 0", n_act); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL enfall_err: got %0b expected 0", err_o); end
    start_run();
    checks++; if (aes_data_o !== plaintext(SEED32, 1'b0)) begin errors++; $display("FAIL enfall_no_shift: got %0h expected %0h", aes_data_o, plaintext(SEED32, 1'b0)); end
    start_at = -1;
    for (int c = 0; c < 256; c++) begin
      if (aes_start_o) start_at = cyc;
      tick();
    end
    checks++; if (start_at != 240) begin errors++; $display("FAIL enfall_counter_cleared: got %0d expected 240", start_at); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    start_run();
    busy_len = 3;
    repeat (256) tick();
    checks++; if (enc_cnt_o !== 16'd1) begin errors++; $display("FAIL midrst_pre_cnt: got %0d expected 1", enc_cnt_o); end
    busy_len = 12;
    for (int c = 0; c < 244; c++) tick();
    checks++; if (trigger_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_trigger: got %0b expected 1", trigger_o); end
    rstn_nxt = 1'b0;
    tick();
    rstn_nxt = 1'b1;
    tick();
    checks++; if (aes_start_o !== 1'b0) begin errors++; $display("FAIL midrst_start: got %0b expected 0", aes_start_o); end
    checks++; if (trigger_o !== 1'b0) begin errors++; $display("FAIL midrst_trigger: got %0b expected 0", trigger_o); end
    checks++; if (class_o !== 1'b0) begin errors++; $display("FAIL midrst_class: got %0b expected 0", class_o); end
    checks++; if (digest_o !== 3'd0) begin errors++; $display("FAIL midrst_digest: got %0h expected 0", digest_o); end
    checks++; if (enc_cnt_o !== 16'd0) begin errors++; $display("FAIL midrst_enc_cnt: got %0d expected 0", enc_cnt_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", err_o); end
    checks++; if (aes_data_o !== plaintext(SEED32, 1'b0)) begin errors++; $display("FAIL midrst_lfsr_seed: got %0h expected %0h", aes_data_o, plaintext(SEED32, 1'b0)); end
  endtask

`ifdef POWER_AES_TVLA_EN
  task automatic test_tvla_class();
    logic [31:0] lf;
    bit cls;
    int ones, bad;
    do_reset();
    start_run();
    busy_len = 0;
    lf = SEED32; cls = 1'b0; ones = 0; bad = 0;
    for (int s = 0; s < 1000; s++) begin
      repeat (240) tick();
      if (!aes_start_o || class_o !== cls || aes_data_o !== plaintext(lf, cls)) bad++;
      repeat (16) tick();
      lf   = lfsr_step(lf);
      cls  = lf[0];
      ones += int'(cls);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tvla_slots: got %0d bad slots expected 0", bad); end
    checks++; if (ones < 450 || ones > 550) begin errors++; $display("FAIL tvla_ratio: got %0d fixed of 1000 expected 450..550", ones); end
  endtask
`endif

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    test_reset();
    test_random_slots();
    test_skip();
    test_timeout();
    test_enable_fall();
    test_reset_midrun();
`ifdef POWER_AES_TVLA_EN
    test_tvla_class();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/power_aes_stim.md
POWER_AES_STIM -- requirements
Module: power_aes_stim

Interface
REQ-001 Parameter PERIOD, 256, cycles per capture slot; legal range 32..65535.
REQ-002 Parameter START_CYC, 240, slot-cycle at which encryption is launched; SHALL satisfy START_CYC < PERIOD-2.
REQ-003 Parameter LFSR_W, 32, LFSR width; legal values 32 or 64.
REQ-004 Parameter SEED, 64'hACE1ACE1ACE1ACE1, LFSR reset value; low LFSR_W bits are used; SHALL be nonzero.
REQ-005 Parameter FIXED_PT, 128'h0, fixed-class plaintext for TVLA mode.
REQ-006 Port ICE_CLK  in  1  clock.
REQ-007 Port resetn  in  1  synchronous reset, active-low.
REQ-008 Port enable_i  in  1  high: slots run; low: counter holds at 0 and no launches occur.
REQ-009 Port aes_busy_i  in  1  busy from the AES core.
REQ-010 Port aes_data_i  in  128  ciphertext from the AES core.
REQ-011 Port aes_start_o  out  1  one-cycle encryption launch pulse.
REQ-012 Port aes_data_o  out  128  plaintext to the AES core, stable from the launch cycle until the end of the slot.
REQ-013 Port trigger_o  out  1  scope trigger, high from the aes_start_o cycle until the first cycle aes_busy_i is low after launch.
REQ-014 Port class_o  out  1  class of the current plaintext (1 = fixed, 0 = random).
REQ-015 Port digest_o  out  3  {XOR, AND, OR} reduction of the last captured ciphertext.
REQ-016 Port enc_cnt_o  out  16  count of completed encryptions; wraps at 0xFFFF.
REQ-017 Port err_o  out  1  sticky flag, set on skip or timeout.

Function
REQ-018 The slot counter SHALL count 0..PERIOD-1, wrap to 0, and advance only while enable_i=1.
REQ-019 The FSM states SHALL be IDLE, WAIT, RUN, and DONE.
REQ-020 IDLE->WAIT when enable_i=1.
REQ-021 In WAIT at counter==START_CYC: if aes_busy_i=0, pulse aes_start_o and go to RUN; else set err_o, stay in WAIT, and launch nothing this slot.
REQ-022 RUN->DONE on the first cycle aes_busy_i=0 that is at least one cycle after launch; in that cycle, latch digest_o from aes_data_i, increment enc_cnt_o, and drop trigger_o.
REQ-023 Timeout: if RUN is still active at counter==PERIOD-1, set err_o, drop trigger_o, go to WAIT, and leave digest_o and enc_cnt_o unchanged.
REQ-024 At counter==PERIOD-1, in any state except IDLE: shift the LFSR once, then the FSM (DONE or WAIT) SHALL enter WAIT at counter 0.
REQ-025 LFSR SHALL be Fibonacci, shift-left, feedback into bit 0; taps: for 32-bit, 32,22,2,1; for 64-bit, 64,63,61,60.
REQ-026 Random plaintext SHALL be the LFSR replicated to 128 bits: 4 copies at 32-bit, 2 copies at 64-bit.
REQ-027 enable_i falling SHALL finish any RUN (REQ-022/023 still apply with the counter frozen, timeout disabled), then go to IDLE with the counter cleared.
REQ-028 Simultaneous timeout and busy-fall at PERIOD-1: completion (REQ-022) wins, and err_o is not set.

Reset
REQ-029 With resetn=0 on a clock edge, the block SHALL return to: FSM IDLE, counter 0, LFSR=SEED, aes_start_o=0, trigger_o=0, class_o=0, digest_o=0, enc_cnt_o=0, err_o=0.
REQ-030 Reset mid-RUN SHALL abandon the encryption with no digest update; the AES core is reset from the same resetn.

Configuration
REQ-031 Macro POWER_AES_TVLA_EN defined: at each LFSR shift, the next class_o SHALL be the new LFSR bit 0.
REQ-032 With POWER_AES_TVLA_EN defined, class 1 SHALL drive aes_data_o=FIXED_PT, and class 0 SHALL drive random plaintext.
REQ-033 With POWER_AES_TVLA_EN undefined: class_o SHALL be tied to 0, aes_data_o SHALL always be random, and no fixed-select logic SHALL exist.

Structure
REQ-034 Package power_aes_pkg SHALL hold the FSM state encoding, the tap constants per LFSR_W, and the default SEED.
REQ-035 The LFSR SHALL be a sub-module power_lfsr with parameters W and SEED, and ports ICE_CLK, resetn, shift_en, and q.
REQ-036 The AES core SHALL be instantiated by the enclosing top, not inside this block.

Verification
REQ-037 Default params, aes_busy_i modelled 12 cycles after start -> aes_start_o pulses at slot cycles 240, 496, ...; trigger_o is high for 13 cycles; enc_cnt_o=1 after the first slot.
REQ-038 After 1 slot with LFSR_W=32 and SEED=32'hACE1ACE1, the slot-2 aes_data_o SHALL equal the replicated value of the once-shifted LFSR, checked against a bench reference model.
REQ-039 aes_busy_i held high across cycle 240 -> no aes_start_o in that slot, err_o=1, and enc_cnt_o unchanged.
REQ-040 aes_busy_i never falls after launch -> timeout at cycle 255, err_o=1, trigger_o low at cycle 256, FSM back in WAIT.
REQ-041 With POWER_AES_TVLA_EN and FIXED_PT=128'h00112233445566778899AABBCCDDEEFF, over 1000 slots: every class_o=1 slot drives FIXED_PT, and the class_o ratio is within 45..55%.
REQ-042 resetn pulsed low at cycle 245 (mid-RUN) -> all outputs at reset values the next cycle, and the LFSR equals SEED.
